// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the framed UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    BODY,
    CSUM,
    ENDER
  } state_e;

  // Bit period in clk cycles, rounded to nearest.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_char_tx.sv
// One-character serialiser: start bit, DATA_WIDTH bits LSB first, STOP_WIDTH stop bits, DIV cycles each.
// ready is also high in the final stop-bit cycle so a new start continues the line with no idle bit.
module uart_char_tx
  import uart_pkg::*;
#(
  parameter int DIV        = 434,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] char_i,
  output logic                  txd_o,
  output logic                  ready_o,
  output logic                  done_o
);

  localparam int NBITS = 1 + DATA_WIDTH + STOP_WIDTH;
  localparam int SW    = DATA_WIDTH + STOP_WIDTH;
  localparam int BW    = cnt_width(DIV);
  localparam int NW    = cnt_width(NBITS);

  logic          busy_q;
  logic [BW-1:0] baud_q;
  logic [NW-1:0] bit_q;
  logic [SW-1:0] shift_q;
  logic          txd_q;
  logic          baud_end;
  logic          last_cycle;

  assign baud_end   = (baud_q == BW'(DIV - 1));
  assign last_cycle = busy_q & baud_end & (bit_q == NW'(NBITS - 1));
  assign ready_o    = ~busy_q | last_cycle;
  assign done_o     = last_cycle;
  assign txd_o      = txd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      txd_q   <= 1'b1;
    end else if (start_i && ready_o) begin
      busy_q  <= 1'b1;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= {{STOP_WIDTH{1'b1}}, char_i};
      txd_q   <= 1'b0;
    end else if (busy_q) begin
      if (baud_end) begin
        baud_q <= '0;
        if (last_cycle) begin
          busy_q <= 1'b0;
          txd_q  <= 1'b1;
        end else begin
          bit_q   <= bit_q + 1'b1;
          txd_q   <= shift_q[0];
          shift_q <= {1'b1, shift_q[SW-1:1]};
        end
      end else begin
        baud_q <= baud_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// Buffers words in a FIFO and sends each as HEADER, payload, [checksum if UART_TX_FRAMER_CHECKSUM_EN], ENDER.
// Empty-FIFO word reaches txd 3 cycles after its handshake; data_ready drops when full, nothing is dropped.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int                    CLK_FREQ     = 50_000_000,
  parameter int                    BAUD_RATE    = 115200,
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    STOP_WIDTH   = 1,
  parameter int                    INDATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH   = 16,
  parameter logic [DATA_WIDTH-1:0] TX_HEADER    = 8'hFF,
  parameter logic [DATA_WIDTH-1:0] TX_ENDER     = 8'hEE,
  parameter int                    MSB_FIRST    = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [INDATA_WIDTH-1:0]              data,
  input  logic                                 data_valid,
  output logic                                 data_ready,
  output logic                                 txd,
  output logic                                 busy,
  output logic [level_width(FIFO_DEPTH)-1:0]   fifo_level
);

  localparam int DIV      = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int BYTE_NUM = INDATA_WIDTH / DATA_WIDTH;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = level_width(FIFO_DEPTH);
  localparam int IW       = cnt_width(BYTE_NUM);

  logic [INDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q;
  logic [AW-1:0]           rd_ptr_q;
  logic [LW-1:0]           count_q;
  logic [LW-1:0]           count_d;
  logic                    ready_q;
  logic                    push;
  logic                    pop;

  state_e                  state_q;
  logic                    start_q;
  logic [DATA_WIDTH-1:0]   char_q;
  logic [INDATA_WIDTH-1:0] word_q;
  logic [IW-1:0]           idx_q;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   csum_q;
`endif

  logic                    eng_ready;
  logic                    eng_done;
  logic                    accept;
  logic                    last_idx;

  assign push       = data_valid & ready_q;
  assign pop        = (state_q == LOAD);
  assign data_ready = ready_q;
  assign fifo_level = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign accept     = start_q & eng_ready;
  assign last_idx   = (idx_q == IW'(BYTE_NUM - 1));

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d != LW'(FIFO_DEPTH));
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  function automatic logic [DATA_WIDTH-1:0] pick(input logic [INDATA_WIDTH-1:0] w,
                                                  input logic [IW-1:0]           idx);
    int sel;
    sel = (MSB_FIRST != 0) ? (BYTE_NUM - 1 - int'(idx)) : int'(idx);
    return w[sel*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // start_q/char_q always hold the next character, so it is taken in the previous one's last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      char_q  <= '0;
      word_q  <= '0;
      idx_q   <= '0;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (count_q != '0 && eng_ready) state_q <= LOAD;
        end
        LOAD: begin
          word_q  <= mem_q[rd_ptr_q];
          idx_q   <= '0;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
          csum_q  <= '0;
`endif
          char_q  <= TX_HEADER;
          start_q <= 1'b1;
          state_q <= HEADER;
        end
        HEADER: begin
          if (accept) begin
            char_q  <= pick(word_q, '0);
            state_q <= BODY;
          end
        end
        BODY: begin
          if (accept) begin
`ifdef UART_TX_FRAMER_CHECKSUM_EN
            csum_q <= csum_q + char_q;
`endif
            if (last_idx) begin
`ifdef UART_TX_FRAMER_CHECKSUM_EN
              char_q  <= csum_q + char_q;
              state_q <= CSUM;
`else
              char_q  <= TX_ENDER;
              state_q <= ENDER;
`endif
            end else begin
              idx_q  <= idx_q + 1'b1;
              char_q <= pick(word_q, idx_q + 1'b1);
            end
          end
        end
`ifdef UART_TX_FRAMER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            char_q  <= TX_ENDER;
            state_q <= ENDER;
          end
        end
`endif
        ENDER: begin
          // done while start_q is still set belongs to the previous character.
          if (accept) begin
            start_q <= 1'b0;
          end else if (!start_q && eng_done) begin
            state_q <= (count_q != '0) ? LOAD : IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          start_q <= 1'b0;
        end
      endcase
    end
  end

  uart_char_tx #(
    .DIV       (DIV),
    .DATA_WIDTH(DATA_WIDTH),
    .STOP_WIDTH(STOP_WIDTH)
  ) u_char_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_q),
    .char_i (char_q),
    .txd_o  (txd),
    .ready_o(eng_ready),
    .done_o (eng_done)
  );

endmodule

// File: tb/tb_uart_tx_framer.sv
// Two framers (LSB-first and MSB-first) share stimulus; a UART line decoder per DUT checks against queued packets.
module tb_uart_tx_framer;

  localparam int DIV      = 10;
  localparam int DEPTH    = 4;
  localparam int BYTE_NUM = 4;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int PKT = (BYTE_NUM + 2 + CS) * 10 * DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready0, data_ready1, txd0, txd1, busy0, busy1;
  logic [2:0]  lvl0, lvl1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic armed = 1'b0;
  logic saw_full;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) armed <= rst_n;

  uart_tx_framer #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .STOP_WIDTH(1),
    .INDATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .TX_HEADER(8'hFF), .TX_ENDER(8'hEE), .MSB_FIRST(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid), .data_ready(data_ready0),
    .txd(txd0), .busy(busy0), .fifo_level(lvl0)
  );

  uart_tx_framer #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .STOP_WIDTH(1),
    .INDATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .TX_HEADER(8'hFF), .TX_ENDER(8'hEE), .MSB_FIRST(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid), .data_ready(data_ready1),
    .txd(txd1), .busy(busy1), .fifo_level(lvl1)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference packet: header, payload bytes in send order, byte-sum checksum, ender.
  task automatic expect_word(input logic [31:0] w);
    logic [7:0] b [4];
    int sum;
    sum = 0;
    for (int k = 0; k < 4; k++) begin
      b[k] = 8'((w >> (8 * k)) & 32'hFF);
      sum += int'(b[k]);
    end
    exp_q0.push_back(8'hFF);
    exp_q1.push_back(8'hFF);
    for (int k = 0; k < 4; k++) begin
      exp_q0.push_back(b[k]);
      exp_q1.push_back(b[3 - k]);
    end
    if (CS != 0) begin
      exp_q0.push_back(8'(sum % 256));
      exp_q1.push_back(8'(sum % 256));
    end
    exp_q0.push_back(8'hEE);
    exp_q1.push_back(8'hEE);
  endtask

  function automatic logic line(input int id);
    return (id != 0) ? txd1 : txd0;
  endfunction

  // Line-level receiver: samples mid-bit; a character interrupted by reset is discarded.
  task automatic decode(input int id);
    logic [7:0] b;
    logic       ok, st, sp;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && line(id) == 1'b0) begin
        ok = 1'b1;
        repeat (DIV / 2 - 1) @(negedge clk);
        st = line(id);
        if (!rst_n) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = line(id);
          if (!rst_n) ok = 1'b0;
        end
        repeat (DIV) @(negedge clk);
        sp = line(id);
        if (!rst_n) ok = 1'b0;
        if (ok) begin
          chk($sformatf("dut%0d_start_bit", id), st, 1'b0);
          chk($sformatf("dut%0d_stop_bit", id), sp, 1'b1);
          if ((id == 0 && exp_q0.size() == 0) || (id != 0 && exp_q1.size() == 0)) begin
            chk($sformatf("dut%0d_unexpected_char", id), b, 9'h100);
          end else begin
            e = (id != 0) ? exp_q1.pop_front() : exp_q0.pop_front();
            chk($sformatf("dut%0d_char", id), b, e);
          end
        end
      end
    end
  endtask

  initial decode(0);
  initial decode(1);

  always @(negedge clk) begin
    if (rst_n && armed) begin
      chk("ready_vs_level", data_ready0, lvl0 != 3'(DEPTH));
      chk("level_le_depth", lvl0 <= 3'(DEPTH), 1'b1);
      chk("dut1_ready_match", data_ready1, data_ready0);
    end
  end

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [31:0] w, input bit hold);
    int t;
    t = 0;
    data       = w;
    data_valid = 1'b1;
    while (!data_ready0 && t < 5000) begin
      if (lvl0 == 3'(DEPTH)) saw_full = 1'b1;
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("send_timeout", 1'b1, 1'b0);
    expect_word(w);
    @(negedge clk);
    if (!hold) data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy0 || busy1) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) chk("idle_timeout", 1'b1, 1'b0);
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_low(output int s);
    int t;
    t = 0;
    while (txd0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("start_timeout", 1'b1, 1'b0);
    s = cyc;
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, m, s;
    rst_n      = 1'b0;
    data       = '0;
    data_valid = 1'b0;
    saw_full   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd0, 1'b1);
    chk("rst_ready", data_ready0, 1'b0);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_level", lvl0, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", data_ready0, 1'b1);

    // Single word: latency, exact packet span, both byte orders.
    send(32'h44332211, 1'b0);
    k = 0;
    while (txd0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 3);
    m = 0;
    while (busy0 && m < PKT + 100) begin
      @(negedge clk);
      m++;
    end
    chk("busy_span", m, PKT);
    wait_idle();
    chk("q0_drained_1", exp_q0.size(), 0);
    chk("q1_drained_1", exp_q1.size(), 0);

    // Checksum wrap and small sum.
    send(32'h80808080, 1'b0);
    send(32'h04030201, 1'b0);
    wait_idle();

    // Valid held through a full FIFO.
    saw_full = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) send($urandom, 1'b1);
    data_valid = 1'b0;
    chk("saw_full_stall", saw_full, 1'b1);
    wait_idle();

    // Push coinciding with the LOAD pop at level DEPTH-1, then wrap the pointers.
    send($urandom, 1'b0);
    wait_low(s);
    for (int i = 0; i < DEPTH - 1; i++) send($urandom, 1'b1);
    data_valid = 1'b0;
    while (cyc < s + PKT) @(negedge clk);
    chk("level_before_pop", lvl0, 3'(DEPTH - 1));
    send($urandom, 1'b0);
    chk("level_push_pop", lvl0, 3'(DEPTH - 1));
    chk("ready_push_pop", data_ready0, 1'b1);
    for (int i = 0; i < 2 * DEPTH - 1; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send($urandom, 1'b0);
    end
    wait_idle();

    // Reset during the first payload character's start bit.
    send(32'h11223344, 1'b0);
    wait_low(s);
    send($urandom, 1'b0);
    send($urandom, 1'b0);
    while (cyc < s + 10 * DIV + 2) @(negedge clk);
    chk("txd_low_before_rst", txd0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    chk("midrst_txd0", txd0, 1'b1);
    chk("midrst_txd1", txd1, 1'b1);
    chk("midrst_level", lvl0, 3'd0);
    chk("midrst_busy", busy0, 1'b0);
    chk("midrst_ready", data_ready0, 1'b0);
    repeat (150) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst", data_ready0, 1'b1);
    send(32'hA5C30F96, 1'b0);
    wait_idle();

    repeat (20) @(negedge clk);
    chk("q0_drained_end", exp_q0.size(), 0);
    chk("q1_drained_end", exp_q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
